// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU data port and data_ram.
// Stores are queued and retired to RAM in the background. Loads read RAM
// combinationally. A load that hits a pending store stalls while the head drains.
// Optional macro STORE_BUF_FWD_EN: a load whose youngest matching entry has all
// byte lanes set is served from the buffer instead of stalling.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ce_i,
    input  logic                   cpu_we_i,
    input  logic [AW-1:0]          cpu_addr_i,
    input  logic [DW/8-1:0]        cpu_sel_i,
    input  logic [DW-1:0]          cpu_data_i,
    output logic [DW-1:0]          cpu_data_o,
    output logic                   stall_req_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [AW-1:0]          ram_addr_o,
    output logic [DW/8-1:0]        ram_sel_o,
    output logic [DW-1:0]          ram_data_o,
    input  logic [DW-1:0]          ram_data_i,
    input  logic                   ram_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned WAW = AW - 2;

    // Entry storage: word address, byte lanes and data per slot
    logic [WAW-1:0] ent_addr_q [DEPTH];
    logic [WAW-1:0] ent_addr_d [DEPTH];
    logic [SW-1:0]  ent_sel_q  [DEPTH];
    logic [SW-1:0]  ent_sel_d  [DEPTH];
    logic [DW-1:0]  ent_data_q [DEPTH];
    logic [DW-1:0]  ent_data_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic             full, empty;
    logic             load, store, load_miss;
    logic             drain, push, pop, stall;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic             hit;
    logic             fwd_ok;
    logic [PW-1:0]    age;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign load  = cpu_ce_i & ~cpu_we_i;
    assign store = cpu_ce_i & cpu_we_i;

    // Slot validity from distance to head, then word-address match against the load
    always_comb begin
        valid = '0;
        match = '0;
        age   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            age      = PW'(i) - rd_ptr_q;
            valid[i] = ({1'b0, age} < count_q);
            match[i] = valid[i] && (ent_addr_q[i] == cpu_addr_i[AW-1:2]);
        end
    end

    assign hit = load & (|match);

`ifdef STORE_BUF_FWD_EN
    logic          young_found;
    logic [PW-1:0] young_idx;
    logic [PW-1:0] scan_idx;
    logic [DW-1:0] fwd_data;

    // Scan oldest to youngest so the last match seen is the youngest one
    always_comb begin
        young_found = 1'b0;
        young_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if (match[scan_idx]) begin
                young_found = 1'b1;
                young_idx   = scan_idx;
            end
        end
    end

    assign fwd_ok   = hit & young_found & (&ent_sel_q[young_idx]);
    assign fwd_data = ent_data_q[young_idx];
`else
    assign fwd_ok = 1'b0;
`endif

    // A load miss owns the RAM port; otherwise the head drains whenever one exists
    assign load_miss = load & ~hit;
    assign drain     = ~empty & ~load_miss;
    assign push      = store & ~full;
    assign pop       = drain & ram_ready_i;
    // Full-buffer stores stall even if a pop happens this cycle
    assign stall     = (hit & ~fwd_ok) | (store & full);

    // Port steering and load data; everything forced to zero while reset is held
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_sel_o   = '0;
        ram_data_o  = '0;
        cpu_data_o  = '0;
        stall_req_o = 1'b0;
        if (rst) begin
            stall_req_o = stall;
            if (load_miss) begin
                ram_ce_o   = 1'b1;
                ram_addr_o = cpu_addr_i;
                ram_sel_o  = cpu_sel_i;
                cpu_data_o = ram_data_i;
            end else if (drain) begin
                ram_ce_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = {ent_addr_q[rd_ptr_q], 2'b00};
                ram_sel_o  = ent_sel_q[rd_ptr_q];
                ram_data_o = ent_data_q[rd_ptr_q];
            end
`ifdef STORE_BUF_FWD_EN
            if (fwd_ok) begin
                cpu_data_o = fwd_data;
            end
`endif
        end
    end

    assign count_o = count_q;

    // Next-state for pointers, occupancy and the slot written by an enqueue
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_addr_d[i] = ent_addr_q[i];
            ent_sel_d[i]  = ent_sel_q[i];
            ent_data_d[i] = ent_data_q[i];
        end
        if (push) begin
            ent_addr_d[wr_ptr_q] = cpu_addr_i[AW-1:2];
            ent_sel_d[wr_ptr_q]  = cpu_sel_i;
            ent_data_d[wr_ptr_q] = cpu_data_i;
        end
    end

    // State registers; reset discards any pending entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_addr_q[i] <= '0;
                ent_sel_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_addr_q[i] <= ent_addr_d[i];
                ent_sel_q[i]  <= ent_sel_d[i];
                ent_data_q[i] <= ent_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a scoreboard of expected RAM writes
// and expected load data, checked by a separate negedge monitor.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall_req;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ready;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    wr_t         mon_w;
    logic [31:0] mon_d;
    logic [31:0] mem [256];

    int vectors;
    int miscompares;

    store_buffer #(
        .DEPTH(4),
        .AW   (32),
        .DW   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_sel_i  (cpu_sel),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stall_req_o(stall_req),
        .ram_ce_o   (ram_ce),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_sel_o  (ram_sel),
        .ram_data_o (ram_wdata),
        .ram_data_i (ram_rdata),
        .ram_ready_i(ready),
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten words read as C0DE_00xx (xx = word index)
    assign ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
        end else if (ram_ce && ram_we && ready) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted RAM write and every completed load is scored
    always @(negedge clk) begin
        if (rst) begin
            if (ram_ce && ram_we && ready) begin
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ram_write: unexpected write addr %h data %h", ram_addr,
                             ram_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", ram_addr, mon_w.addr);
                    chk("wr_data", ram_wdata, mon_w.data);
                    chk("wr_sel", 32'(ram_sel), 32'(mon_w.sel));
                end
            end
            if (cpu_ce && !cpu_we && !stall_req) begin
                if (exp_ld.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL load: unexpected load completion data %h", cpu_rdata);
                end else begin
                    mon_d = exp_ld.pop_front();
                    chk("load_data", cpu_rdata, mon_d);
                end
            end
        end
    end

    task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        cpu_ce    = ce;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_sel   = s;
        cpu_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input bit expect_write);
        drive(1'b1, 1'b1, a, s, d);
        if (expect_write) exp_wr.push_back('{addr: a, data: d, sel: s});
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        ready       = 1'b1;
        drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);

        // Reset held: outputs all zero even with a load presented
        repeat (3) @(posedge clk);
        settle();
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_cpu_data", cpu_rdata, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'h5);
        settle();
        chk("rst_store_ram_we", 32'(ram_we), 32'd0);
        chk("rst_store_stall", 32'(stall_req), 32'd0);
        adv();
        rst = 1'b1;

        // Single store then idle: written one cycle after acceptance
        store(32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        settle();
        chk("t1_stall", 32'(stall_req), 32'd0);
        adv();
        chk("t1_count_after_store", 32'(count), 32'd1);
        idle();
        settle();
        chk("t1_ram_we", 32'(ram_we), 32'd1);
        adv();
        chk("t1_count_after_drain", 32'(count), 32'd0);

        // Fill with ready low, 5th store stalls until one pop frees a slot
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 4'hF, 32'h100 + 32'(i), 1'b1);
            settle();
            chk("t2_fill_stall", 32'(stall_req), 32'd0);
            adv();
        end
        chk("t2_count_full", 32'(count), 32'd4);
        store(32'h10, 4'hF, 32'h104, 1'b0);
        settle();
        chk("t2_full_stall", 32'(stall_req), 32'd1);
        adv();
        chk("t2_count_held", 32'(count), 32'd4);
        ready = 1'b1;
        settle();
        chk("t2_stall_during_pop", 32'(stall_req), 32'd1);
        adv();
        chk("t2_count_after_pop", 32'(count), 32'd3);
        ready = 1'b0;
        exp_wr.push_back('{addr: 32'h10, data: 32'h104, sel: 4'hF});
        settle();
        chk("t2_accept_stall", 32'(stall_req), 32'd0);
        adv();
        chk("t2_count_after_accept", 32'(count), 32'd4);
        idle();
        ready = 1'b1;
        repeat (4) adv();
        chk("t2_count_drained", 32'(count), 32'd0);

        // Pointer wrap: 10 store/idle pairs retire in order
        for (int i = 0; i < 10; i++) begin
            store(32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 1'b1);
            adv();
            idle();
            adv();
        end
        chk("t3_count", 32'(count), 32'd0);

        // Load hazard: hit on the younger entry drains both before completing
        ready = 1'b0;
        store(32'h20, 4'hF, 32'h11111111, 1'b1);
        adv();
        store(32'h24, 4'hF, 32'h22222222, 1'b1);
        adv();
        chk("t4_count", 32'(count), 32'd2);
        drive(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        ready = 1'b1;
        exp_ld.push_back(32'h22222222);
`ifdef STORE_BUF_FWD_EN
        settle();
        chk("t4_fwd_stall", 32'(stall_req), 32'd0);
        adv();
        idle();
        adv();
`else
        settle();
        chk("t4_stall_c1", 32'(stall_req), 32'd1);
        adv();
        settle();
        chk("t4_stall_c2", 32'(stall_req), 32'd1);
        adv();
        settle();
        chk("t4_stall_c3", 32'(stall_req), 32'd0);
        adv();
`endif
        chk("t4_count_after", 32'(count), 32'd0);

        // Load miss with a store pending: no stall, no drain, count unchanged
        ready = 1'b0;
        store(32'h20, 4'hF, 32'h33333333, 1'b1);
        adv();
        drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        exp_ld.push_back(32'hC0DE0010);
        settle();
        chk("t5_stall", 32'(stall_req), 32'd0);
        chk("t5_ram_we", 32'(ram_we), 32'd0);
        chk("t5_ram_addr", ram_addr, 32'h40);
        adv();
        chk("t5_count", 32'(count), 32'd1);
        idle();
        ready = 1'b1;
        adv();
        chk("t5_count_drained", 32'(count), 32'd0);

        // Partial byte-lane store merges into the RAM word
        store(32'h50, 4'b0011, 32'h12345678, 1'b1);
        adv();
        idle();
        adv();
        drive(1'b1, 1'b0, 32'h50, 4'hF, 32'h0);
        exp_ld.push_back(32'hC0DE5678);
        settle();
        chk("t6_stall", 32'(stall_req), 32'd0);
        adv();
        idle();

`ifdef STORE_BUF_FWD_EN
        // Forwarding: youngest full-word match wins without stalling
        ready = 1'b0;
        store(32'h30, 4'hF, 32'hA, 1'b1);
        adv();
        store(32'h30, 4'hF, 32'hB, 1'b1);
        adv();
        drive(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        exp_ld.push_back(32'hB);
        settle();
        chk("t7_fwd_stall", 32'(stall_req), 32'd0);
        adv();
        chk("t7_count_no_pop", 32'(count), 32'd2);
        idle();
        ready = 1'b1;
        repeat (2) adv();
        // Partial-lane youngest match cannot forward: stall until drained
        ready = 1'b0;
        store(32'h30, 4'b0011, 32'hA, 1'b1);
        adv();
        store(32'h30, 4'b0011, 32'hB, 1'b1);
        adv();
        drive(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        ready = 1'b1;
        exp_ld.push_back(32'hB);
        settle();
        chk("t7_part_stall_c1", 32'(stall_req), 32'd1);
        adv();
        settle();
        chk("t7_part_stall_c2", 32'(stall_req), 32'd1);
        adv();
        settle();
        chk("t7_part_stall_c3", 32'(stall_req), 32'd0);
        adv();
        idle();
`endif

        // Asynchronous reset mid-cycle discards a pending store
        ready = 1'b0;
        store(32'h60, 4'hF, 32'h66666666, 1'b0);
        adv();
        chk("t8_count_pending", 32'(count), 32'd1);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("t8_async_count", 32'(count), 32'd0);
        chk("t8_async_ram_ce", 32'(ram_ce), 32'd0);
        adv();
        rst   = 1'b1;
        ready = 1'b1;
        settle();
        chk("t8_post_reset_ram_ce", 32'(ram_ce), 32'd0);
        adv();
        adv();

        chk("wr_queue_left", 32'(exp_wr.size()), 32'd0);
        chk("ld_queue_left", 32'(exp_ld.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
